// File: rtl/iot_riscv_int_pkg.sv
// -----------------------------------------------------------------------------
// iot_riscv_int_pkg
// Shared types and constants for the interrupt pending / claim block.
//   state_e        : claim state of the controller (IDLE, CLAIMED)
//   IRQ_WIDTH_DEF  : default number of interrupt lines
//   ID_WIDTH_DEF   : default width of an interrupt index, clog2(IRQ_WIDTH_DEF)
// -----------------------------------------------------------------------------
package iot_riscv_int_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    CLAIMED = 1'b1
  } state_e;

  localparam int unsigned IRQ_WIDTH_DEF = 32;
  localparam int unsigned ID_WIDTH_DEF  = $clog2(IRQ_WIDTH_DEF);

endpackage : iot_riscv_int_pkg

// File: rtl/iot_riscv_int_prio.sv
// -----------------------------------------------------------------------------
// iot_riscv_int_prio
// Combinational fixed-priority encoder: the lowest index whose pending bit and
// mask bit are both set wins.
// Ports:
//   vec_i   [width_p]   pending vector
//   mask_i  [width_p]   per-line enable
//   id_o    [id_w_p]    index of the winning line (0 when none)
//   valid_o             a winning line exists
// -----------------------------------------------------------------------------
module iot_riscv_int_prio #(
  parameter int unsigned width_p = 32,
  parameter int unsigned id_w_p  = 5
) (
  input  logic [width_p-1:0] vec_i,
  input  logic [width_p-1:0] mask_i,
  output logic [id_w_p-1:0]  id_o,
  output logic               valid_o
);

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise an unassigned path infers a latch.
  always_comb begin
    id_o    = '0;
    valid_o = 1'b0;
    // Scan from the top down so the lowest matching index is the last write.
    for (int i = int'(width_p) - 1; i >= 0; i--) begin
      if (vec_i[i] && mask_i[i]) begin
        id_o    = id_w_p'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule : iot_riscv_int_prio

// File: rtl/iot_riscv_int_pend.sv
// -----------------------------------------------------------------------------
// iot_riscv_int_pend
// Interrupt pending register with edge/level capture, lowest-index priority
// selection and a single-claim handshake with the core (ack on entry, done on
// mret).
//
// Configuration macro:
//   IOT_RISCV_INT_PEND_SYNC_EN  defined   : every source line passes a 2-flop
//                                           synchronizer (source -> irq_o = 3 clk)
//                               undefined : sources must be main_clk_i
//                                           synchronous (source -> irq_o = 1 clk)
//
// Ports:
//   main_clk_i      clock, all state on rising edge
//   main_rst_an_i   asynchronous active-low reset
//   irq_src_i       raw interrupt lines
//   irq_edge_i      per-line mode: 1 = rising edge, 0 = level
//   irq_mask_i      per-line enable for selection only
//   irq_ack_i       core entered the indicated interrupt
//   irq_done_i      core executed mret
//   irq_o           registered pending vector
//   irq_id_o        index of the selected / claimed interrupt
//   irq_id_valid_o  irq_id_o is meaningful
//   irq_claimed_o   a claim is active
// -----------------------------------------------------------------------------
module iot_riscv_int_pend
  import iot_riscv_int_pkg::*;
#(
  parameter int unsigned irq_width_p = IRQ_WIDTH_DEF,
  parameter int unsigned id_width_p  = ID_WIDTH_DEF
) (
  input  logic                   main_clk_i,
  input  logic                   main_rst_an_i,
  input  logic [irq_width_p-1:0] irq_src_i,
  input  logic [irq_width_p-1:0] irq_edge_i,
  input  logic [irq_width_p-1:0] irq_mask_i,
  input  logic                   irq_ack_i,
  input  logic                   irq_done_i,
  output logic [irq_width_p-1:0] irq_o,
  output logic [id_width_p-1:0]  irq_id_o,
  output logic                   irq_id_valid_o,
  output logic                   irq_claimed_o
);

  logic [irq_width_p-1:0] w_sync;
  logic [irq_width_p-1:0] r_prev;
  logic [irq_width_p-1:0] r_pend;
  logic [irq_width_p-1:0] w_edge_set;
  logic [irq_width_p-1:0] w_claim_clr;
  logic [irq_width_p-1:0] w_pend_nxt;
  logic [id_width_p-1:0]  w_sel;
  logic                   w_cand;
  logic                   w_claim_take;

  state_e                 r_state;
  logic [id_width_p-1:0]  r_id;
  logic                   r_id_valid;
  logic                   r_claimed;

  // ---------------------------------------------------------------------------
  // Source conditioning
  // ---------------------------------------------------------------------------
`ifdef IOT_RISCV_INT_PEND_SYNC_EN
  logic [irq_width_p-1:0] r_sync_meta;
  logic [irq_width_p-1:0] r_sync;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      r_sync_meta <= '0;
      r_sync      <= '0;
    end else begin
      r_sync_meta <= irq_src_i;
      r_sync      <= r_sync_meta;
    end
  end

  assign w_sync = r_sync;
`else
  assign w_sync = irq_src_i;
`endif

  // ---------------------------------------------------------------------------
  // Pending capture
  // ---------------------------------------------------------------------------
  // prev resets to 0, so a line already high when reset releases is seen as a
  // rising edge and latches exactly one pending.
  assign w_edge_set = w_sync & ~r_prev;

  // A claim is accepted only in IDLE while an id is being offered.
  assign w_claim_take = (r_state == IDLE) && irq_ack_i && r_id_valid;

  always_comb begin
    w_claim_clr = '0;
    for (int i = 0; i < int'(irq_width_p); i++) begin
      w_claim_clr[i] = w_claim_take && irq_edge_i[i] && (r_id == id_width_p'(i));
    end
  end

  // Edge lines: a fresh edge wins over a simultaneous claim clear.
  // Level lines: follow the conditioned source, untouched by claims.
  assign w_pend_nxt = (irq_edge_i & ((r_pend & ~w_claim_clr) | w_edge_set))
                    | (~irq_edge_i & w_sync);

  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      r_prev <= '0;
      r_pend <= '0;
    end else begin
      r_prev <= w_sync;
      r_pend <= w_pend_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Priority selection
  // ---------------------------------------------------------------------------
  iot_riscv_int_prio #(
    .width_p (irq_width_p),
    .id_w_p  (id_width_p)
  ) u_prio (
    .vec_i   (r_pend),
    .mask_i  (irq_mask_i),
    .id_o    (w_sel),
    .valid_o (w_cand)
  );

  // ---------------------------------------------------------------------------
  // Claim FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      r_state    <= IDLE;
      r_id       <= '0;
      r_id_valid <= 1'b0;
      r_claimed  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_claim_take) begin
            // id and valid freeze at the claimed value; done is ignored here.
            r_state   <= CLAIMED;
            r_claimed <= 1'b1;
          end else begin
            r_id       <= w_sel;
            r_id_valid <= w_cand;
          end
        end
        CLAIMED: begin
          if (irq_done_i) begin
            // Re-evaluate on the same edge so the next cycle shows a fresh id.
            r_state    <= IDLE;
            r_claimed  <= 1'b0;
            r_id       <= w_sel;
            r_id_valid <= w_cand;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign irq_o          = r_pend;
  assign irq_id_o       = r_id;
  assign irq_id_valid_o = r_id_valid;
  assign irq_claimed_o  = r_claimed;

endmodule : iot_riscv_int_pend

// File: doc/iot_riscv_int_pend.md
IOT_RISCV_INT_PEND -- requirements
Module: iot_riscv_int_pend

Interface
REQ-001 SHALL have parameter irq_width_p, default 32, number of interrupt lines (2..32).
REQ-002 SHALL have parameter id_width_p, default 5, width of an interrupt index (= clog2(irq_width_p)).
REQ-003 SHALL have main_clk_i  input  1  single clock, all state on rising edge.
REQ-004 SHALL have main_rst_an_i  input  1  Async Reset (Low-Active).
REQ-005 SHALL have irq_src_i  input  irq_width_p  raw peripheral interrupt lines, possibly asynchronous.
REQ-006 SHALL have irq_edge_i  input  irq_width_p  per-line mode, 1 = rising-edge, 0 = level (quasi-static).
REQ-007 SHALL have irq_mask_i  input  irq_width_p  per-line enable, used only for priority selection.
REQ-008 SHALL have irq_ack_i  input  1  pulse: core has entered the interrupt currently indicated.
REQ-009 SHALL have irq_done_i  input  1  pulse: core executed mret.
REQ-010 SHALL have irq_o  output  irq_width_p  pending vector, feeds downstream irq_i.
REQ-011 SHALL have irq_id_o  output  id_width_p  index of selected/claimed interrupt.
REQ-012 SHALL have irq_id_valid_o  output  1  irq_id_o is meaningful.
REQ-013 SHALL have irq_claimed_o  output  1  claim active (between ack and done).

Function
REQ-014 Sync stage SHALL produce sync_s per line (see Configuration); prev_r SHALL register sync_s each cycle.
REQ-015 Edge line: pend_r[i] SHALL set when sync_s[i] & ~prev_r[i]; SHALL stay set until cleared by claim.
REQ-016 Level line: pend_r[i] SHALL equal sync_s[i] delayed one cycle; claim clear SHALL not affect it.
REQ-017 Set and claim-clear on the same edge line in the same cycle: set SHALL win (pend stays 1).
REQ-018 irq_o SHALL equal pend_r (registered, no combinational path from irq_src_i).
REQ-019 Selection: sel = lowest index i with pend_r[i] & irq_mask_i[i]; none -> no candidate.
REQ-020 State IDLE: irq_id_o/irq_id_valid_o SHALL register sel/candidate-exists each cycle (1-cycle latency).
REQ-021 IDLE -> CLAIMED on irq_ack_i & irq_id_valid_o: id SHALL freeze, irq_claimed_o=1, pend_r[irq_id_o] cleared if edge line.
REQ-022 irq_ack_i while irq_id_valid_o=0 SHALL be ignored (no state change).
REQ-023 CLAIMED: irq_id_o and irq_id_valid_o=1 SHALL hold; further irq_ack_i ignored; new pendings still latch.
REQ-024 CLAIMED -> IDLE on irq_done_i; next cycle id output re-evaluates per REQ-020.
REQ-025 irq_done_i in IDLE SHALL be ignored; irq_ack_i and irq_done_i same cycle in IDLE: ack processed, done ignored.
REQ-026 Mask change SHALL never clear pend_r; masked pending lines remain visible on irq_o.
REQ-027 Latency irq_src_i rise -> irq_o: 3 cycles with sync, 1 cycle without.

Reset
REQ-028 Asynchronous assert on main_rst_an_i low, synchronous-effect release; all flops SHALL reset to 0.
REQ-029 Reset values: irq_o=0, irq_id_o=0, irq_id_valid_o=0, irq_claimed_o=0, state IDLE.
REQ-030 prev_r resets to 0: an edge line already high at reset release SHALL latch one pending.
REQ-031 Reset mid-claim SHALL drop the claim and all pendings; no ack/done memory retained.

Configuration
REQ-032 IOT_RISCV_INT_PEND_SYNC_EN defined: each line SHALL pass a 2-flop synchronizer before edge/level logic.
REQ-033 Macro undefined: sync_s SHALL be irq_src_i directly; sources SHALL be main_clk_i-synchronous.

Structure
REQ-034 Package iot_riscv_int_pkg SHALL hold the state enum (IDLE, CLAIMED) and id-width helper constant.
REQ-035 Priority encoder SHALL be sub-module iot_riscv_int_prio (combinational, vector+mask in, id+valid out).

Verification
REQ-036 Edge line 3 pulse 1 cycle, mask all 1 -> irq_o[3]=1 after 3 cycles (sync on), irq_id_o=3 valid next cycle.
REQ-037 Lines 5 and 2 edge-pending, ack -> id 2 claimed, pend[2]=0, pend[5]=1; done -> id 5 one cycle later.
REQ-038 Level line 7 held high, ack then done -> pend[7] stays 1; irq_src_i[7] low -> irq_o[7]=0 after latency.
REQ-039 Line 4 edge arrives same cycle as ack of id 4 -> pend[4] remains 1.
REQ-040 Edge line 0 high across reset release -> irq_o[0]=1; assert reset while CLAIMED -> all outputs 0 immediately.
REQ-041 Mask line 1 pending to 0 -> irq_o[1]=1, irq_id_valid_o=0; ack ignored, irq_claimed_o stays 0.
